// File: rtl/mawg_pkg.sv
// Shared definitions for the waveform generator output stages: serializer state
// encoding and the signed-to-offset-binary conversion used by every DAC output.
package mawg_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_e;

    // Widest sample any DAC output may carry; callers zero/sign-extend into this.
    localparam int unsigned OB_MAX_W = 64;

    // Two's complement to offset binary is a flip of the sign bit at position w-1.
    function automatic logic [OB_MAX_W-1:0] to_offset_binary(
        input logic [OB_MAX_W-1:0] s,
        input int unsigned         w
    );
        logic [OB_MAX_W-1:0] msb_mask;
        msb_mask        = '0;
        msb_mask[w-1]   = 1'b1;
        return s ^ msb_mask;
    endfunction

endpackage

// File: rtl/dac_serializer_sclk_gen.sv
// Phase timer for the serial clock: emits one-cycle rise/fall strobes every DIV
// clk cycles while enabled, starting from the low phase after a clear.
module sclk_gen
    import mawg_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clear_i,
    output logic rise_tick_o,
    output logic fall_tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          phase_q;
    logic          phase_d;
    logic          tick;

    assign tick = en_i && !clear_i && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (en_i) begin
            if (tick) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // phase_q low means the current half-period is the sclk-low phase.
    assign rise_tick_o = tick && !phase_q;
    assign fall_tick_o = tick &&  phase_q;

endmodule

// File: rtl/dac_serializer.sv
// Serial DAC output stage: captures one signed sample per frame, converts it to
// offset binary and shifts it out MSB-first on sclk/sdata/cs_n.
module dac_serializer
    import mawg_pkg::*;
#(
    parameter int M   = 16,
    parameter int DIV = 2,
    parameter int GAP = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [M-1:0] sample,
    input  logic                valid,
    output logic                ready,
    output logic                sclk,
    output logic                sdata,
    output logic                cs_n,
    output logic                frame_done
);

    localparam int BW = $clog2(M);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    ser_state_e    state_q, state_d;
    logic [M-1:0]  shreg_q, shreg_d;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [GW-1:0] gapcnt_q, gapcnt_d;
    logic          ready_q, ready_d;
    logic          sclk_q, sclk_d;
    logic          sdata_q, sdata_d;
    logic          cs_n_q, cs_n_d;
    logic          frame_done_q, frame_done_d;

    logic          accept;
    logic          rise_tick;
    logic          fall_tick;
    logic [M-1:0]  conv;

    assign conv = M'(to_offset_binary(OB_MAX_W'(sample), M));

    sclk_gen #(
        .DIV(DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q == S_SHIFT),
        .clear_i    (accept),
        .rise_tick_o(rise_tick),
        .fall_tick_o(fall_tick)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        gapcnt_d     = gapcnt_q;
        ready_d      = 1'b0;
        sclk_d       = sclk_q;
        sdata_d      = sdata_q;
        cs_n_d       = cs_n_q;
        frame_done_d = 1'b0;
        accept       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ready_q gates acceptance so the first edge after reset only raises ready.
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                if (valid && ready_q) begin
                    accept   = 1'b1;
                    ready_d  = 1'b0;
                    shreg_d  = conv;
                    bitcnt_d = BW'(M - 1);
                    sdata_d  = conv[M-1];
                    cs_n_d   = 1'b0;
                    state_d  = S_SHIFT;
                end
            end

            S_SHIFT: begin
                cs_n_d = 1'b0;
                if (rise_tick) begin
                    sclk_d = 1'b1;
                end else if (fall_tick) begin
                    sclk_d = 1'b0;
                    if (bitcnt_q != '0) begin
                        shreg_d  = shreg_q << 1;
                        sdata_d  = shreg_q[M-2];
                        bitcnt_d = bitcnt_q - 1'b1;
                    end else begin
                        cs_n_d       = 1'b1;
                        frame_done_d = 1'b1;
                        gapcnt_d     = '0;
                        state_d      = S_GAP;
                    end
                end
            end

            S_GAP: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (gapcnt_q == GW'(GAP - 1)) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gapcnt_d = gapcnt_q + 1'b1;
                end
            end

            default: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            gapcnt_q     <= '0;
            ready_q      <= 1'b0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            cs_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            gapcnt_q     <= gapcnt_d;
            ready_q      <= ready_d;
            sclk_q       <= sclk_d;
            sdata_q      <= sdata_d;
            cs_n_q       <= cs_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ready      = ready_q;
    assign sclk       = sclk_q;
    assign sdata      = sdata_q;
    assign cs_n       = cs_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Directed bench for dac_serializer: default instance (DIV=2, GAP=2) and a fast
// corner instance (DIV=1, GAP=1), checked against a queue of expected words.
module tb_dac_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sample = 16'h0000;
    logic        valid = 1'b0;
    bit          sel = 1'b0;

    logic ready0, sclk0, sdata0, cs_n0, fd0;
    logic ready1, sclk1, sdata1, cs_n1, fd1;
    logic valid0, valid1;
    logic o_ready, o_sclk, o_sdata, o_cs_n, o_fd;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    bit          free_mode = 1'b0;
    bit          have_last = 1'b0;
    int          last_k = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid0  = valid & ~sel;
    assign valid1  = valid &  sel;
    assign o_ready = sel ? ready1 : ready0;
    assign o_sclk  = sel ? sclk1  : sclk0;
    assign o_sdata = sel ? sdata1 : sdata0;
    assign o_cs_n  = sel ? cs_n1  : cs_n0;
    assign o_fd    = sel ? fd1    : fd0;

    dac_serializer #(.M(16), .DIV(2), .GAP(2)) dut0 (
        .clk(clk), .rst(rst), .sample(sample), .valid(valid0), .ready(ready0),
        .sclk(sclk0), .sdata(sdata0), .cs_n(cs_n0), .frame_done(fd0)
    );

    dac_serializer #(.M(16), .DIV(1), .GAP(1)) dut1 (
        .clk(clk), .rst(rst), .sample(sample), .valid(valid1), .ready(ready1),
        .sclk(sclk1), .sdata(sdata1), .cs_n(cs_n1), .frame_done(fd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Offers a sample (or the free-running counter), then follows the whole frame
    // cycle by cycle. Observation label t = cyc+1 at each falling edge.
    task automatic frame(input string tag, input logic [15:0] s, input logic [15:0] expw);
        int div, gap, per, k, t, rel, bitidx, nrise, csl, fdn, fd_t, tries;
        logic [15:0] word, tgt, popped;
        bit rise_ok, stab_ok, rdy_ok, prev_sclk;
        div = sel ? 1 : 2;
        gap = sel ? 1 : 2;
        per = 1 + 32 * div + gap;
        nrise = 0; csl = 0; fdn = 0; fd_t = -1; tries = 0;
        word = 16'h0000; rise_ok = 1'b1; stab_ok = 1'b1; rdy_ok = 1'b1; prev_sclk = 1'b0;
        if (!free_mode) sample = s;
        valid = 1'b1;
        while (o_ready !== 1'b1 && tries < 200) begin
            @(negedge clk);
            tries++;
            if (free_mode) sample = sample + 16'd1;
        end
        if (o_ready !== 1'b1) begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
            valid = 1'b0;
            return;
        end
        tgt = free_mode ? (sample ^ 16'h8000) : expw;
        k = int'(cyc) + 1;
        exp_q.push_back(tgt);
        if (free_mode && have_last) chk({tag, "_period"}, k - last_k, per);
        last_k = k;
        have_last = 1'b1;
        @(negedge clk);
        if (free_mode) sample = sample + 16'd1;
        else valid = 1'b0;
        chk({tag, "_first_cs_n"}, o_cs_n, 0);
        chk({tag, "_first_ready"}, o_ready, 0);
        for (t = k + 1; t <= k + per; t++) begin
            rel = t - k - 1;
            if (rel < 32 * div) begin
                bitidx = rel / (2 * div);
                if (o_sdata !== tgt[15 - bitidx]) stab_ok = 1'b0;
                if (o_sclk !== ((rel % (2 * div)) >= div)) rise_ok = 1'b0;
            end
            if (o_sclk === 1'b1 && !prev_sclk && o_cs_n === 1'b0) begin
                word = {word[14:0], o_sdata};
                nrise++;
            end
            if (o_cs_n === 1'b0) csl++;
            if (o_fd === 1'b1) begin fdn++; fd_t = t; end
            if (o_ready !== (t == k + per)) rdy_ok = 1'b0;
            prev_sclk = o_sclk;
            if (t < k + per) begin
                @(negedge clk);
                if (free_mode) sample = sample + 16'd1;
            end
        end
        popped = exp_q.pop_front();
        chk({tag, "_word"}, word, popped);
        chk({tag, "_nrise"}, nrise, 16);
        chk({tag, "_cs_low_cycles"}, csl, 32 * div);
        chk({tag, "_frame_done_count"}, fdn, 1);
        chk({tag, "_frame_done_time"}, fd_t - k, 1 + 32 * div);
        chk({tag, "_sclk_timing"}, rise_ok, 1);
        chk({tag, "_sdata_stable"}, stab_ok, 1);
        chk({tag, "_ready_timing"}, rdy_ok, 1);
        $display("frame %s: k=%0d word=0x%h expected=0x%h", tag, k, word, popped);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset from idle
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", cs_n0, 1);
        chk("rst_sclk", sclk0, 0);
        chk("rst_ready", ready0, 0);
        chk("rst_sdata", sdata0, 0);
        chk("rst_frame_done", fd0, 0);
        chk("rst_ready_fast", ready1, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_ready", ready0, 0);
        rst = 1'b1;
        chk("rst_release_ready", ready0, 0);
        @(negedge clk);
        chk("rst_ready_after_edge", ready0, 1);
        $display("reset: ready=%b cs_n=%b sclk=%b", ready0, cs_n0, sclk0);

        // Offset-binary corner values on the default instance
        frame("hi_7fff", 16'h7FFF, 16'hFFFF);
        frame("lo_8001", 16'h8001, 16'h0001);
        frame("zero",    16'h0000, 16'h8000);
        frame("min_8000", 16'h8000, 16'h0000);

        // Free-running source: valid held high, sample changes every cycle
        free_mode = 1'b1;
        have_last = 1'b0;
        sample = 16'h0100;
        for (int i = 0; i < 4; i++) frame($sformatf("free%0d", i), 16'h0000, 16'h0000);
        valid = 1'b0;
        free_mode = 1'b0;

        // Reset in the middle of a frame (sclk high during bit 7)
        sample = 16'h5A5A;
        valid = 1'b1;
        chk("midrst_pre_ready", ready0, 1);
        @(negedge clk);
        valid = 1'b0;
        repeat (31) @(negedge clk);
        chk("midrst_pre_sclk", sclk0, 1);
        chk("midrst_pre_cs_n", cs_n0, 0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_cs_n", cs_n0, 1);
        chk("midrst_sclk", sclk0, 0);
        chk("midrst_frame_done", fd0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_frame_done", fd0, 0);
        end
        rst = 1'b1;
        chk("midrst_release_ready", ready0, 0);
        @(negedge clk);
        chk("midrst_ready_after", ready0, 1);
        $display("midframe reset: cs_n=%b sclk=%b", cs_n0, sclk0);
        frame("after_rst_1234", 16'h1234, 16'h9234);

        // Fast corner instance: DIV=1, GAP=1, 34-cycle frames
        sel = 1'b1;
        frame("fast_a5c3", 16'hA5C3, 16'h25C3);
        free_mode = 1'b1;
        have_last = 1'b0;
        sample = 16'hFFF0;
        for (int i = 0; i < 3; i++) frame($sformatf("fast_free%0d", i), 16'h0000, 16'h0000);
        valid = 1'b0;
        free_mode = 1'b0;

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
